// File: rtl/arm_shift_pkg.sv
// ============================================================================
// Module  : arm_shift_pkg
// Shared ARM shift encodings, sequencer states and IR field helpers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package arm_shift_pkg;

  typedef enum logic [1:0] {
    LSL = 2'b00,
    LSR = 2'b01,
    ASR = 2'b10,
    ROR = 2'b11
  } shift_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam int c_ir_op_hi    = 27;
  localparam int c_ir_op_lo    = 25;
  localparam int c_ir_rs_hi    = 11;
  localparam int c_ir_rs_lo    = 8;
  localparam int c_ir_bit7     = 7;
  localparam int c_ir_type_hi  = 6;
  localparam int c_ir_type_lo  = 5;
  localparam int c_ir_regsh    = 4;
  localparam int c_cnt_w       = 6;

  function automatic logic is_reg_shift(input logic [31:0] ir);
    return (ir[c_ir_op_hi:c_ir_op_lo] == 3'b000) && !ir[c_ir_bit7] && ir[c_ir_regsh];
  endfunction

  // Shift distances past the point where the result saturates are clamped.
  function automatic logic [c_cnt_w-1:0] eff_count(input shift_t t, input logic [7:0] a);
    logic [c_cnt_w-1:0] n;
    case (t)
      LSL, LSR: n = (a > 8'd33) ? 6'd33 : a[5:0];
      ASR:      n = (a > 8'd32) ? 6'd32 : a[5:0];
      default:  n = {1'b0, a[4:0]};
    endcase
    return n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_shift_sequencer_if.sv
// ============================================================================
// Module  : reg_shift_sequencer_if
// Request, register-read and result bus; `illegal` exists with REG_SHIFT_ILLEGAL_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface reg_shift_sequencer_if;
  logic        start;
  logic [31:0] IR;
  logic [31:0] BReg;
  logic        C_in;
  logic [3:0]  rs_addr;
  logic        rs_rd;
  logic [31:0] rs_data;
  logic [31:0] sOperand;
  logic        carry;
  logic        busy;
  logic        done;
`ifdef REG_SHIFT_ILLEGAL_EN
  logic        illegal;

  modport master (
    output start, IR, BReg, C_in, rs_data,
    input  rs_addr, rs_rd, sOperand, carry, busy, done, illegal
  );
  modport slave (
    input  start, IR, BReg, C_in, rs_data,
    output rs_addr, rs_rd, sOperand, carry, busy, done, illegal
  );
`else
  modport master (
    output start, IR, BReg, C_in, rs_data,
    input  rs_addr, rs_rd, sOperand, carry, busy, done
  );
  modport slave (
    input  start, IR, BReg, C_in, rs_data,
    output rs_addr, rs_rd, sOperand, carry, busy, done
  );
`endif
endinterface

`default_nettype wire

// File: rtl/shift_step_unit.sv
// ============================================================================
// Module  : shift_step_unit
// One combinational ARM shift step of up to STEP bits, carrying the last bit out.
// Revision: 1.0
// ============================================================================
`default_nettype none

module shift_step_unit
  import arm_shift_pkg::*;
(
  input  logic [31:0]        i_value,
  input  logic [c_cnt_w-1:0] i_count,
  input  shift_t             i_type,
  input  logic               i_carry,
  output logic [31:0]        o_value,
  output logic               o_carry
);

  logic [32:0]        w_lsl;
  logic [32:0]        w_lsr;
  logic signed [32:0] w_asr;
  logic [31:0]        w_ror;

  // The incoming carry rides in the 33rd bit so a zero count passes it through.
  always_comb begin
    w_lsl   = {i_carry, i_value} << i_count;
    w_lsr   = {i_value, i_carry} >> i_count;
    w_asr   = $signed({i_value, i_carry}) >>> i_count;
    w_ror   = (i_value >> i_count) | (i_value << (6'd32 - i_count));
    o_value = i_value;
    o_carry = i_carry;
    case (i_type)
      LSL: begin
        o_value = w_lsl[31:0];
        o_carry = w_lsl[32];
      end
      LSR: begin
        o_value = w_lsr[32:1];
        o_carry = w_lsr[0];
      end
      ASR: begin
        o_value = w_asr[32:1];
        o_carry = w_asr[0];
      end
      default: begin
        o_value = w_ror;
        o_carry = (i_count == '0) ? i_carry : w_ror[31];
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/reg_shift_sequencer.sv
// ============================================================================
// Module  : reg_shift_sequencer
// Multi-cycle register-specified shifter; REG_SHIFT_ILLEGAL_EN adds IR form check.
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_shift_sequencer
  import arm_shift_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  reg_shift_sequencer_if.slave bus
);

  localparam logic [c_cnt_w-1:0] c_step = c_cnt_w'(STEP);

  state_t             r_state;
  logic [31:0]        r_val;
  logic               r_wcarry;
  shift_t             r_type;
  logic [c_cnt_w-1:0] r_rem;
  logic [3:0]         r_rs_addr;
  logic               r_rs_rd;
  logic               r_busy;
  logic               r_done;
  logic [31:0]        r_soperand;
  logic               r_carry;

  logic [7:0]         w_a;
  logic [c_cnt_w-1:0] w_n;
  logic               w_ror_wrap;
  logic [c_cnt_w-1:0] w_step;
  logic [31:0]        w_sh_val;
  logic               w_sh_carry;
  logic               w_legal;

  assign w_a        = bus.rs_data[7:0];
  assign w_n        = eff_count(r_type, w_a);
  // ROR by a nonzero multiple of 32 leaves the value but still reports bit 31.
  assign w_ror_wrap = (r_type == ROR) && (w_a != 8'd0) && (w_a[4:0] == 5'd0);
  assign w_step     = (r_rem > c_step) ? c_step : r_rem;

`ifdef REG_SHIFT_ILLEGAL_EN
  logic r_illegal;
  assign w_legal     = is_reg_shift(bus.IR);
  assign bus.illegal = r_illegal;
`else
  assign w_legal = 1'b1;
`endif

  shift_step_unit u_step (
    .i_value (r_val),
    .i_count (w_step),
    .i_type  (r_type),
    .i_carry (r_wcarry),
    .o_value (w_sh_val),
    .o_carry (w_sh_carry)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_val      <= '0;
      r_wcarry   <= 1'b0;
      r_type     <= LSL;
      r_rem      <= '0;
      r_rs_addr  <= '0;
      r_rs_rd    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_soperand <= '0;
      r_carry    <= 1'b0;
`ifdef REG_SHIFT_ILLEGAL_EN
      r_illegal  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
          if (bus.start) begin
            r_val     <= bus.BReg;
            r_wcarry  <= bus.C_in;
            r_type    <= shift_t'(bus.IR[c_ir_type_hi:c_ir_type_lo]);
            r_rs_addr <= bus.IR[c_ir_rs_hi:c_ir_rs_lo];
`ifdef REG_SHIFT_ILLEGAL_EN
            r_illegal <= !w_legal;
`endif
            if (w_legal) begin
              r_state <= READ;
              r_rs_rd <= 1'b1;
              r_busy  <= 1'b1;
            end else begin
              r_state    <= DONE;
              r_done     <= 1'b1;
              r_soperand <= bus.BReg;
              r_carry    <= bus.C_in;
            end
          end
        end
        READ: begin
          r_rs_rd <= 1'b0;
          r_state <= LOAD;
        end
        LOAD: begin
          if (w_ror_wrap) begin
            r_wcarry <= r_val[31];
          end
          if (w_n == '0) begin
            r_state    <= DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_soperand <= r_val;
            r_carry    <= w_ror_wrap ? r_val[31] : r_wcarry;
          end else begin
            r_rem   <= w_n;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_val    <= w_sh_val;
          r_wcarry <= w_sh_carry;
          r_rem    <= r_rem - w_step;
          if (r_rem == w_step) begin
            r_state    <= DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_soperand <= w_sh_val;
            r_carry    <= w_sh_carry;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.rs_addr  = r_rs_addr;
  assign bus.rs_rd    = r_rs_rd;
  assign bus.sOperand = r_soperand;
  assign bus.carry    = r_carry;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;

endmodule

`default_nettype wire

// File: tb/tb_reg_shift_sequencer.sv
// ============================================================================
// Module  : tb_reg_shift_sequencer
// Directed self-checking bench for reg_shift_sequencer (STEP=4).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_reg_shift_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  logic [31:0] regs [16];
  logic [31:0] res;
  logic [31:0] held;
  logic        cy;
  logic        bsy1;
  logic [3:0]  addr1;
  int          lat;
  int          nrd;

  reg_shift_sequencer_if bus ();

  reg_shift_sequencer #(.STEP(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: data appears the cycle after the read strobe.
  always @(posedge clk) begin
    bus.rs_data <= bus.rs_rd ? regs[bus.rs_addr] : 32'hDEAD_BEEF;
  end

  function automatic logic [31:0] make_ir(input logic [1:0] t, input logic [3:0] rs);
    return 32'hE000_0010 | {20'd0, rs, 1'b0, t, 5'd0};
  endfunction

  task automatic run_op(input logic [31:0] ir, input logic [31:0] breg, input logic cin);
    bus.start = 1'b1;
    bus.IR    = ir;
    bus.BReg  = breg;
    bus.C_in  = cin;
    lat = 0;
    nrd = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        bus.start = 1'b0;
        bus.IR    = ~ir;
        bus.BReg  = ~breg;
        bus.C_in  = ~cin;
        held  = bus.sOperand;
        bsy1  = bus.busy;
        addr1 = bus.rs_addr;
      end
      if (bus.rs_rd) nrd++;
    end while (!bus.done && lat < 80);
    if (!bus.done) lat = -1;
    res = bus.sOperand;
    cy  = bus.carry;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.IR    = '0;
    bus.BReg  = '0;
    bus.C_in  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.rs_rd, bus.carry, bus.rs_addr, bus.sOperand} !== 38'd0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b done=%b rs_rd=%b carry=%b rs_addr=%h sOperand=%h expected all 0",
               bus.busy, bus.done, bus.rs_rd, bus.carry, bus.rs_addr, bus.sOperand);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_lsl;
    regs[3] = 32'd4;
    run_op(make_ir(2'b00, 4'd3), 32'h0000_0001, 1'b0);
    checks++;
    if ({res, cy} !== {32'h0000_0010, 1'b0}) begin
      failures++; $display("FAIL lsl4: got %h/%b expected 00000010/0", res, cy);
    end
    checks++;
    if (lat !== 4) begin
      failures++; $display("FAIL lsl4_latency: got %0d expected 4", lat);
    end
    checks++;
    if ({nrd, bsy1, addr1} !== {32'd1, 1'b1, 4'd3}) begin
      failures++; $display("FAIL lsl4_read: got rs_rd_cycles=%0d busy=%b rs_addr=%h expected 1/1/3", nrd, bsy1, addr1);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.done, bus.busy, bus.sOperand} !== {2'b00, 32'h0000_0010}) begin
      failures++; $display("FAIL done_pulse: got done=%b busy=%b sOperand=%h expected 0/0/00000010",
                           bus.done, bus.busy, bus.sOperand);
    end
    regs[3] = 32'hFFFF_FF05;
    run_op(make_ir(2'b00, 4'd3), 32'h0800_0001, 1'b0);
    checks++;
    if ({res, cy, lat} !== {32'h0000_0020, 1'b1, 32'd5}) begin
      failures++; $display("FAIL lsl5: got %h/%b lat %0d expected 00000020/1 lat 5", res, cy, lat);
    end
    regs[3] = 32'd32;
    run_op(make_ir(2'b00, 4'd3), 32'h0000_0001, 1'b0);
    checks++;
    if ({res, cy, lat} !== {32'h0, 1'b1, 32'd11}) begin
      failures++; $display("FAIL lsl32: got %h/%b lat %0d expected 00000000/1 lat 11", res, cy, lat);
    end
    regs[3] = 32'h0000_0100;
    run_op(make_ir(2'b00, 4'd3), 32'hA5A5_A5A5, 1'b1);
    checks++;
    if ({res, cy, lat} !== {32'hA5A5_A5A5, 1'b1, 32'd3}) begin
      failures++; $display("FAIL lsl0: got %h/%b lat %0d expected a5a5a5a5/1 lat 3", res, cy, lat);
    end
  endtask

  task automatic test_lsr;
    regs[3] = 32'd32;
    run_op(make_ir(2'b01, 4'd3), 32'h8000_0000, 1'b0);
    checks++;
    if ({res, cy, lat} !== {32'h0, 1'b1, 32'd11}) begin
      failures++; $display("FAIL lsr32: got %h/%b lat %0d expected 00000000/1 lat 11", res, cy, lat);
    end
    regs[3] = 32'd33;
    run_op(make_ir(2'b01, 4'd3), 32'h8000_0000, 1'b1);
    checks++;
    if ({res, cy, lat} !== {32'h0, 1'b0, 32'd12}) begin
      failures++; $display("FAIL lsr33: got %h/%b lat %0d expected 00000000/0 lat 12", res, cy, lat);
    end
    regs[3] = 32'd3;
    run_op(make_ir(2'b01, 4'd3), 32'h0000_000C, 1'b0);
    checks++;
    if ({res, cy, lat} !== {32'h1, 1'b1, 32'd4}) begin
      failures++; $display("FAIL lsr3: got %h/%b lat %0d expected 00000001/1 lat 4", res, cy, lat);
    end
  endtask

  task automatic test_asr;
    regs[3] = 32'h0000_00C8;
    run_op(make_ir(2'b10, 4'd3), 32'h8000_0000, 1'b0);
    checks++;
    if ({res, cy, lat} !== {32'hFFFF_FFFF, 1'b1, 32'd11}) begin
      failures++; $display("FAIL asr200: got %h/%b lat %0d expected ffffffff/1 lat 11", res, cy, lat);
    end
    regs[3] = 32'd4;
    run_op(make_ir(2'b10, 4'd3), 32'h8000_000F, 1'b0);
    checks++;
    if ({res, cy, lat} !== {32'hF800_0000, 1'b1, 32'd4}) begin
      failures++; $display("FAIL asr4: got %h/%b lat %0d expected f8000000/1 lat 4", res, cy, lat);
    end
    regs[3] = 32'd32;
    run_op(make_ir(2'b10, 4'd3), 32'h7FFF_FFFF, 1'b1);
    checks++;
    if ({res, cy, lat} !== {32'h0, 1'b0, 32'd11}) begin
      failures++; $display("FAIL asr32_pos: got %h/%b lat %0d expected 00000000/0 lat 11", res, cy, lat);
    end
  endtask

  task automatic test_ror;
    regs[3] = 32'h0000_0100;
    run_op(make_ir(2'b11, 4'd3), 32'h1234_5678, 1'b1);
    checks++;
    if ({res, cy, lat} !== {32'h1234_5678, 1'b1, 32'd3}) begin
      failures++; $display("FAIL ror_a0: got %h/%b lat %0d expected 12345678/1 lat 3", res, cy, lat);
    end
    regs[3] = 32'd8;
    run_op(make_ir(2'b11, 4'd3), 32'h1234_5678, 1'b1);
    checks++;
    if ({res, cy, lat} !== {32'h7812_3456, 1'b0, 32'd5}) begin
      failures++; $display("FAIL ror8: got %h/%b lat %0d expected 78123456/0 lat 5", res, cy, lat);
    end
    regs[3] = 32'd32;
    run_op(make_ir(2'b11, 4'd3), 32'h1234_5678, 1'b1);
    checks++;
    if ({res, cy, lat} !== {32'h1234_5678, 1'b0, 32'd3}) begin
      failures++; $display("FAIL ror32: got %h/%b lat %0d expected 12345678/0 lat 3", res, cy, lat);
    end
    regs[3] = 32'h0000_0024;
    run_op(make_ir(2'b11, 4'd3), 32'h1234_5678, 1'b0);
    checks++;
    if ({res, cy, lat} !== {32'h8123_4567, 1'b1, 32'd4}) begin
      failures++; $display("FAIL ror36: got %h/%b lat %0d expected 81234567/1 lat 4", res, cy, lat);
    end
  endtask

  task automatic test_back_to_back;
    regs[3] = 32'd4;
    regs[7] = 32'd8;
    run_op(make_ir(2'b00, 4'd3), 32'h0000_0001, 1'b0);
    run_op(make_ir(2'b11, 4'd7), 32'h1234_5678, 1'b0);
    checks++;
    if (held !== 32'h0000_0010) begin
      failures++; $display("FAIL b2b_hold: got %h expected 00000010", held);
    end
    checks++;
    if ({res, cy, lat, addr1} !== {32'h7812_3456, 1'b0, 32'd5, 4'd7}) begin
      failures++; $display("FAIL b2b_second: got %h/%b lat %0d addr %h expected 78123456/0 lat 5 addr 7",
                           res, cy, lat, addr1);
    end
  endtask

  task automatic test_start_busy;
    int n;
    logic seen;
    regs[3] = 32'd8;
    regs[5] = 32'd1;
    bus.start = 1'b1;
    bus.IR    = make_ir(2'b11, 4'd3);
    bus.BReg  = 32'h1234_5678;
    bus.C_in  = 1'b0;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      seen = bus.done;
      if (n == 1) begin
        bus.IR   = make_ir(2'b00, 4'd5);
        bus.BReg = 32'hFFFF_FFFF;
        bus.C_in = 1'b1;
      end
      if (n == 4) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    checks++;
    if ({seen, bus.sOperand, bus.carry, bus.rs_addr, n} !== {1'b1, 32'h7812_3456, 1'b0, 4'd3, 32'd5}) begin
      failures++; $display("FAIL start_busy: got done=%b %h/%b addr %h lat %0d expected 1 78123456/0 addr 3 lat 5",
                           seen, bus.sOperand, bus.carry, bus.rs_addr, n);
    end
  endtask

  task automatic test_reset_mid;
    int seen;
    regs[7] = 32'd8;
    run_op(make_ir(2'b11, 4'd7), 32'h1234_5678, 1'b1);
    @(posedge clk);
    #1;
    regs[3] = 32'd32;
    bus.start = 1'b1;
    bus.IR    = make_ir(2'b01, 4'd3);
    bus.BReg  = 32'h8000_0000;
    bus.C_in  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
    checks++;
    if ({bus.busy, bus.sOperand} !== {1'b1, 32'h7812_3456}) begin
      failures++; $display("FAIL mid_busy: got busy=%b sOperand=%h expected 1/78123456", bus.busy, bus.sOperand);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.done, bus.carry, bus.sOperand} !== 35'd0) begin
      failures++; $display("FAIL async_reset: got busy=%b done=%b carry=%b sOperand=%h expected all 0",
                           bus.busy, bus.done, bus.carry, bus.sOperand);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++; $display("FAIL reset_no_done: got %0d active cycles expected 0", seen);
    end
  endtask

  task automatic test_ir_form;
`ifdef REG_SHIFT_ILLEGAL_EN
    run_op(32'hE3A0_0001, 32'hCAFE_F00D, 1'b1);
    checks++;
    if ({res, cy, lat, nrd, bus.illegal} !== {32'hCAFE_F00D, 1'b1, 32'd1, 32'd0, 1'b1}) begin
      failures++; $display("FAIL illegal_op: got %h/%b lat %0d rs_rd_cycles %0d illegal %b expected cafef00d/1 lat 1 0 1",
                           res, cy, lat, nrd, bus.illegal);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({bus.illegal, bus.done} !== 2'b10) begin
      failures++; $display("FAIL illegal_hold: got illegal=%b done=%b expected 1/0", bus.illegal, bus.done);
    end
    regs[3] = 32'd4;
    run_op(make_ir(2'b00, 4'd3), 32'h0000_0001, 1'b0);
    checks++;
    if ({res, bus.illegal} !== {32'h0000_0010, 1'b0}) begin
      failures++; $display("FAIL illegal_clear: got %h illegal=%b expected 00000010/0", res, bus.illegal);
    end
`else
    regs[0] = 32'd4;
    run_op(32'hE3A0_0001, 32'h0000_0001, 1'b0);
    checks++;
    if ({res, cy, lat, nrd} !== {32'h0000_0010, 1'b0, 32'd4, 32'd1}) begin
      failures++; $display("FAIL no_form_check: got %h/%b lat %0d rs_rd_cycles %0d expected 00000010/0 lat 4 1",
                           res, cy, lat, nrd);
    end
`endif
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 16; i++) regs[i] = 32'd0;
    test_reset();
    test_lsl();
    test_lsr();
    test_asr();
    test_ror();
    test_back_to_back();
    test_start_busy();
    test_reset_mid();
    test_ir_form();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
